// File: rtl/log_pkg.sv
// Shared types and constants for the log-domain dot-product datapath.
// Log numbers are sign-enclosed: top bit is the sign, the rest is a fixed-point log2 magnitude.
package log_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} logseq_state_t;

    localparam bit LOG_ZERO = '0;

    function automatic int sign_of(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/log_prod_buffer.sv
// z-entry product register file: all entries written in one cycle, one entry read by index.
// Combinational read, one-cycle write; no flow control of its own.
module log_prod_buffer #(
    parameter int z     = 4,
    parameter int width = 16,
    parameter int KW    = (z > 1) ? $clog2(z) : 1
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [width*z-1:0] wr_data,
    input  logic [KW-1:0]      rd_idx,
    output logic [width-1:0]   rd_data
);

    logic [width-1:0] prod_q [z];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < z; i++) begin
                prod_q[i] <= wr_data[width*i +: width];
            end
        end
    end

    assign rd_data = prod_q[rd_idx];

endmodule

// File: rtl/logadder.sv
// Log-domain adder: larger magnitude plus/minus a correction of 1.0 >> floor(|ma-mb|).
// Purely combinational; exact cancellation of equal opposite-sign operands returns all-zero.
module logadder
    import log_pkg::*;
#(
    parameter int width    = 16,
    parameter int int_bits = 5
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] s
);

    localparam int SB   = sign_of(width);
    localparam int MW   = width - 1;
    localparam int FRAC = MW - int_bits;
    localparam logic [MW-1:0] ONE = MW'(1) << FRAC;

    logic [MW-1:0] ma, mb, mbig, d, corr;
    logic          a_ge, sbig;

    always_comb begin
        ma   = a[MW-1:0];
        mb   = b[MW-1:0];
        a_ge = (ma >= mb);
        mbig = a_ge ? ma : mb;
        sbig = a_ge ? a[SB] : b[SB];
        d    = a_ge ? (ma - mb) : (mb - ma);
        corr = ONE >> d[MW-1:FRAC];
        if (a[SB] == b[SB]) begin
            s = {sbig, mbig + corr};
        end else if (d == '0) begin
            s = '0;
        end else begin
            s = {sbig, mbig - corr};
        end
    end

endmodule

// File: rtl/logmultiplier_set.sv
// z parallel log-domain multipliers: sign XOR, magnitude add (wraps, no saturation).
// Purely combinational; no flow control.
module logmultiplier_set
    import log_pkg::*;
#(
    parameter int z        = 4,
    parameter int width    = 16,
    parameter int int_bits = 5
) (
    input  logic [width*z-1:0] a_set,
    input  logic [width*z-1:0] b_set,
    output logic [width*z-1:0] p_set
);

    localparam int SB   = sign_of(width);
    localparam int FRAC = width - 1 - int_bits;

    for (genvar i = 0; i < z; i++) begin : g_el
        logic [width-1:0]    a_e;
        logic [width-1:0]    b_e;
        logic [FRAC:0]       f_sum;
        logic [int_bits-1:0] i_sum;

        assign a_e   = a_set[width*i +: width];
        assign b_e   = b_set[width*i +: width];
        // Fraction and integer fields summed separately with an explicit carry.
        assign f_sum = {1'b0, a_e[FRAC-1:0]} + {1'b0, b_e[FRAC-1:0]};
        assign i_sum = a_e[SB-1:FRAC] + b_e[SB-1:FRAC] + int_bits'(f_sum[FRAC]);
        assign p_set[width*i +: width] = {a_e[SB] ^ b_e[SB], i_sum, f_sum[FRAC-1:0]};
    end

endmodule

// File: rtl/log_dot_sequencer.sv
// Dot product over any number of z-wide beats: z parallel multiplies, then a serial fold; z+2 cycles per beat.
// in_ready only in IDLE; the result is held on out_valid/out_data until out_ready.
module log_dot_sequencer
    import log_pkg::*;
#(
    parameter int z        = 4,
    parameter int width    = 16,
    parameter int int_bits = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width*z-1:0] a_set,
    input  logic [width*z-1:0] b_set,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width-1:0]   out_data,
    output logic               busy
);

    localparam int KW = (z > 1) ? $clog2(z) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(z - 1);

    logseq_state_t      state_q;
    logic [width*z-1:0] a_q, b_q, prod_set;
    logic [width-1:0]   acc_q, acc_d, prod_k, sum;
    logic [KW-1:0]      k_q;
    logic               first_q, last_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logmultiplier_set #(.z(z), .width(width), .int_bits(int_bits)) u_mul (
        .a_set (a_q),
        .b_set (b_q),
        .p_set (prod_set)
    );

    log_prod_buffer #(.z(z), .width(width), .KW(KW)) u_buf (
        .clk     (clk),
        .wr_en   (state_q == MUL),
        .wr_data (prod_set),
        .rd_idx  (k_q),
        .rd_data (prod_k)
    );

    logadder #(.width(width), .int_bits(int_bits)) u_add (
        .a (acc_q),
        .b (prod_k),
        .s (sum)
    );

    // The first product of a job seeds the accumulator rather than being added to zero.
    assign acc_d = first_q ? prod_k : sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= {width{LOG_ZERO}};
            k_q         <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_set;
                        b_q        <= b_set;
                        last_q     <= in_last;
                        state_q    <= MUL;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL: begin
                    k_q     <= '0;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q   <= acc_d;
                    first_q <= 1'b0;
                    if (k_q == K_LAST) begin
                        k_q <= '0;
                        if (last_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= {width{LOG_ZERO}};
                        first_q     <= 1'b1;
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_log_dot_sequencer.sv
// Directed bench for log_dot_sequencer with a beat-level reference model checked every cycle.
module tb_log_dot_sequencer;

    localparam int Z = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W*Z-1:0] a_set, b_set;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_acc    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    log_dot_sequencer #(.z(Z), .width(W), .int_bits(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_set     (a_set),
        .b_set     (b_set),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Reference arithmetic: 1 sign bit, 15-bit magnitude with 10 fractional bits.
    function automatic logic [15:0] lmul(input logic [15:0] a, input logic [15:0] b);
        int m = (int'(a[14:0]) + int'(b[14:0])) % 32768;
        return {a[15] ^ b[15], m[14:0]};
    endfunction

    function automatic logic [15:0] ladd(input logic [15:0] a, input logic [15:0] b);
        int ma = int'(a[14:0]);
        int mb = int'(b[14:0]);
        int big, d, corr, r;
        bit s;
        if (ma >= mb) begin big = ma; d = ma - mb; s = a[15]; end
        else          begin big = mb; d = mb - ma; s = b[15]; end
        corr = 1024 >> (d / 1024);
        if (a[15] == b[15]) r = (big + corr) % 32768;
        else if (d == 0)    return 16'h0000;
        else                r = (big - corr + 32768) % 32768;
        return {s, r[14:0]};
    endfunction

    function automatic logic [15:0] fold_beat(input logic [15:0] acc_in, input bit first,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [15:0] acc = acc_in;
        for (int i = 0; i < Z; i++) begin
            if (first && i == 0) acc = lmul(a[16*i +: 16], b[16*i +: 16]);
            else                 acc = ladd(acc, lmul(a[16*i +: 16], b[16*i +: 16]));
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat-level model: a beat is accepted, then the block is busy z+1 more cycles.
    int          m_cnt = 0;
    bit          m_done = 0, m_first = 1, m_last = 0;
    logic [15:0] m_acc = '0, m_result = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_done = 0; m_first = 1; m_last = 0;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && m_last) m_done = 1;
        end else if (in_valid) begin
            m_acc   = fold_beat(m_acc, m_first, a_set, b_set);
            m_first = 0;
            m_last  = in_last;
            m_cnt   = Z + 1;
            if (in_last) begin m_result = m_acc; m_first = 1; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, (m_cnt == 0 && !m_done)});
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_cnt != 0 || m_done)});
            check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_done});
            if (m_done) check("cyc_out_data", {16'd0, out_data}, {16'd0, m_result});
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input bit last);
        int n = 0;
        @(negedge clk);
        a_set = a; b_set = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=busy required=in_ready");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_acc = cyc;
        if (last) in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [15:0] exp, input int exp_lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 200);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_lat > 0) check({name, "_latency"}, n, exp_lat);
        check({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
        @(posedge clk); #1;
    endtask

    logic [63:0] a1, a2, a3, b1, b2, b3;
    logic [15:0] g, held;
    int t1;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_set = '0; b_set = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: single beat, all 2.0 * 2.0, four-term sum is 16.0 = log 4.0.
        send({4{16'h0400}}, {4{16'h0400}}, 1'b1);
        check("t1_in_ready_drop", {31'd0, in_ready}, 32'd0);
        get_result("t1", 16'h1000, Z + 2);

        // 2: three beats, in_valid held high.
        a1 = {16'h0C00, 16'h0100, 16'h8300, 16'h0050}; b1 = {16'h0200, 16'h0400, 16'h0010, 16'h8100};
        a2 = {16'h8A00, 16'h0700, 16'h0000, 16'h0400}; b2 = {16'h0100, 16'h8200, 16'h0300, 16'h0400};
        a3 = {16'h0123, 16'h8456, 16'h0789, 16'h0ABC}; b3 = {16'h0400, 16'h0400, 16'h8400, 16'h0400};
        g = fold_beat(fold_beat(fold_beat(16'h0, 1'b1, a1, b1), 1'b0, a2, b2), 1'b0, a3, b3);
        send(a1, b1, 1'b0); t1 = t_acc;
        send(a2, b2, 1'b0); check("t2_beat_period_2", t_acc - t1, Z + 2); t1 = t_acc;
        send(a3, b3, 1'b1); check("t2_beat_period_3", t_acc - t1, Z + 2);
        get_result("t2", g, Z + 2);

        // 3: consumer stalls for 10 cycles.
        out_ready = 1'b0;
        send(a2, b1, 1'b1);
        get_result("t3", fold_beat(16'h0, 1'b1, a2, b1), Z + 2);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_data", {16'd0, out_data}, {16'd0, held});
            check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("t3_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // 4: in_valid/a_set wiggle while busy must not be captured.
        send(a1, b2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a_set = {$urandom, $urandom};
        end
        send(a3, b1, 1'b1);
        get_result("t4", fold_beat(fold_beat(16'h0, 1'b1, a1, b2), 1'b0, a3, b1), Z + 2);

        // 5: reset in the ACC phase of beat 2 abandons the job.
        send(a2, b3, 1'b0);
        send(a1, b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_out_data", {16'd0, out_data}, 32'd0);
        reset = 1'b0;
        send(a3, b2, 1'b1);
        get_result("t5", fold_beat(16'h0, 1'b1, a3, b2), Z + 2);

        // 6: mixed signs exercise the subtract path.
        send({16'h8400, 16'h0200, 16'h8100, 16'h0000}, {4{16'h0400}}, 1'b1);
        get_result("t6", 16'h8600, Z + 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
